// File: rtl/garage_pkg.sv
// Shared types for the garage door controller: FSM state encodings
// (visible on state_o for debug) and the remembered travel direction.
package garage_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    MV_UP = 3'b001,
    MV_DN = 3'b011,
    STOP  = 3'b100,
    FAULT = 3'b111
  } state_t;

  typedef enum logic {
    UP = 1'b0,
    DN = 1'b1
  } dir_t;

  // True for the two states in which a motor is energised.
  function automatic logic is_motion(input state_t s);
    return (s == MV_UP) || (s == MV_DN);
  endfunction

endpackage

// File: rtl/garage_travel_timer.sv
// Travel watchdog: counts consecutive motor-on cycles of one run and flags
// the cycle in which the run reaches its allowed length.
module garage_travel_timer #(
  parameter int TRAVEL_MAX = 1000,
  parameter int CNT_W      = $clog2(TRAVEL_MAX + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  localparam logic [CNT_W-1:0] LAST_CYCLE = CNT_W'(TRAVEL_MAX - 1);
  localparam logic [CNT_W-1:0] SAT_VALUE  = CNT_W'(TRAVEL_MAX);

  logic [CNT_W-1:0] count_reg;

  // Restart on a new run, hold at zero outside motion, saturate instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clr || !en) begin
      count_reg <= '0;
    end else if (count_reg != SAT_VALUE) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  // Count equals the number of completed motor-on cycles minus one, so this
  // fires during the last permitted cycle of the run.
  assign timeout = (count_reg == LAST_CYCLE);

endmodule

// File: rtl/garage_ctrl_v2.sv
// Single-door garage motor controller: one push-button, two limit switches,
// obstruction beam, travel watchdog and latched fault with explicit clear.
module garage_ctrl_v2
  import garage_pkg::*;
#(
  parameter int TRAVEL_MAX       = 1000,
  parameter int CNT_W            = $clog2(TRAVEL_MAX + 1),
  parameter bit OBSTRUCT_REVERSE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       activate,
  input  logic       up_max,
  input  logic       dn_max,
  input  logic       obstruct,
  input  logic       fault_clr,
  output logic       up_m,
  output logic       dn_m,
  output logic       fault,
  output logic [2:0] state_o
);

  state_t state_reg, state_next;
  dir_t   last_dir_reg, last_dir_next;
  logic   activate_q;
  logic   act_pulse;
  logic   conflict;
  logic   timeout;
  logic   timer_clr;
  logic   timer_en;

  assign act_pulse = activate & ~activate_q;
  assign conflict  = up_max & dn_max;

  // A new run starts whenever a motion state is entered from any other state
  // (including the down-to-up reversal); the count only advances while the
  // same motion state is kept across the edge.
  assign timer_clr = is_motion(state_next) && (state_next != state_reg);
  assign timer_en  = is_motion(state_reg) && (state_next == state_reg);

  garage_travel_timer #(
    .TRAVEL_MAX(TRAVEL_MAX),
    .CNT_W     (CNT_W)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (timer_clr),
    .en     (timer_en),
    .timeout(timeout)
  );

  // State, remembered direction and button history registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      last_dir_reg <= UP;
      activate_q   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      last_dir_reg <= last_dir_next;
      activate_q   <= activate;
    end
  end

  // Next-state logic; a sensor conflict overrides everything except FAULT itself.
  always_comb begin
    state_next    = state_reg;
    last_dir_next = last_dir_reg;
    if (state_reg != FAULT && conflict) begin
      state_next = FAULT;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (act_pulse) begin
            // Only an open door moves down; closed or mid-way defaults to up.
            state_next = (up_max && !dn_max) ? MV_DN : MV_UP;
          end
        end
        MV_UP: begin
          if (up_max) begin
            state_next = IDLE;
          end else if (act_pulse) begin
            state_next    = STOP;
            last_dir_next = UP;
          end else if (timeout) begin
            state_next = FAULT;
          end
        end
        MV_DN: begin
          if (dn_max) begin
            state_next = IDLE;
          end else if (obstruct) begin
            if (OBSTRUCT_REVERSE) begin
              state_next = MV_UP;
            end else begin
              state_next    = STOP;
              last_dir_next = DN;
            end
          end else if (act_pulse) begin
            state_next    = STOP;
            last_dir_next = DN;
          end else if (timeout) begin
            state_next = FAULT;
          end
        end
        STOP: begin
          if (act_pulse) begin
            if (last_dir_reg == DN) begin
              state_next = MV_UP;
            end else if (!obstruct) begin
              state_next = MV_DN;
            end else if (OBSTRUCT_REVERSE) begin
              // Never start closing onto a blocked beam.
              state_next = MV_UP;
            end
          end
        end
        FAULT: begin
          if (fault_clr && !conflict) begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Moore output decode from the registered state only.
  always_comb begin
    up_m    = (state_reg == MV_UP);
    dn_m    = (state_reg == MV_DN);
    fault   = (state_reg == FAULT);
    state_o = state_reg;
  end

endmodule

// File: tb/tb_garage_ctrl_v2.sv
// Scoreboard bench: two controllers (reverse-on-obstruct and stop-on-obstruct)
// share one stimulus stream; a reference model predicts each cycle's outputs.
module tb_garage_ctrl_v2;

  localparam int TM = 16;

  localparam int M_IDLE  = 0;
  localparam int M_UP    = 1;
  localparam int M_DN    = 2;
  localparam int M_STOP  = 3;
  localparam int M_FAULT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic activate = 1'b0, up_max = 1'b0, dn_max = 1'b0, obstruct = 1'b0, fault_clr = 1'b0;

  logic       up_m_r, dn_m_r, fault_r;
  logic [2:0] state_r;
  logic       up_m_s, dn_m_s, fault_s;
  logic [2:0] state_s;

  int checks = 0;
  int errors = 0;

  // model state: index 0 = reversing DUT, 1 = stopping DUT
  int mode [2];
  int runs [2];
  bit last_up [2];
  bit prev_act;

  logic [11:0] exp_q [$];

  always #5 clk = ~clk;

  garage_ctrl_v2 #(.TRAVEL_MAX(TM), .OBSTRUCT_REVERSE(1'b1)) dut_rev (
    .clk(clk), .rst(rst), .activate(activate), .up_max(up_max), .dn_max(dn_max),
    .obstruct(obstruct), .fault_clr(fault_clr),
    .up_m(up_m_r), .dn_m(dn_m_r), .fault(fault_r), .state_o(state_r)
  );

  garage_ctrl_v2 #(.TRAVEL_MAX(TM), .OBSTRUCT_REVERSE(1'b0)) dut_stp (
    .clk(clk), .rst(rst), .activate(activate), .up_max(up_max), .dn_max(dn_max),
    .obstruct(obstruct), .fault_clr(fault_clr),
    .up_m(up_m_s), .dn_m(dn_m_s), .fault(fault_s), .state_o(state_s)
  );

  // {state_o, up_m, dn_m, fault} expected for a model mode
  function automatic logic [5:0] expect_bits(input int m);
    case (m)
      M_UP:    return 6'b001_100;
      M_DN:    return 6'b011_010;
      M_STOP:  return 6'b100_000;
      M_FAULT: return 6'b111_001;
      default: return 6'b000_000;
    endcase
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      mode[k] = M_IDLE;
      runs[k] = 0;
      last_up[k] = 1'b1;
    end
    prev_act = 1'b0;
  endfunction

  // One clock edge of door behaviour; runs counts completed motor-on cycles.
  function automatic void model_step(input int k, input bit rev, input bit pulse,
                                     input bit u, input bit d, input bit o, input bit c);
    int m;
    int nm;
    m  = mode[k];
    nm = m;
    if (m == M_UP || m == M_DN) runs[k] = runs[k] + 1;
    if (m != M_FAULT && u && d) begin
      nm = M_FAULT;
    end else begin
      case (m)
        M_IDLE: if (pulse) nm = (u && !d) ? M_DN : M_UP;
        M_UP: begin
          if (u) nm = M_IDLE;
          else if (pulse) begin nm = M_STOP; last_up[k] = 1'b1; end
          else if (runs[k] == TM) nm = M_FAULT;
        end
        M_DN: begin
          if (d) nm = M_IDLE;
          else if (o) begin
            if (rev) nm = M_UP;
            else begin nm = M_STOP; last_up[k] = 1'b0; end
          end
          else if (pulse) begin nm = M_STOP; last_up[k] = 1'b0; end
          else if (runs[k] == TM) nm = M_FAULT;
        end
        M_STOP: begin
          if (pulse) begin
            if (!last_up[k]) nm = M_UP;
            else if (!o) nm = M_DN;
            else if (rev) nm = M_UP;
          end
        end
        default: if (c && !(u && d)) nm = M_IDLE;
      endcase
    end
    if (nm != m || !(nm == M_UP || nm == M_DN)) runs[k] = 0;
    mode[k] = nm;
  endfunction

  task automatic compare(input string name, input logic [5:0] got, input logic [5:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got state=%b up=%b dn=%b fault=%b, expected state=%b up=%b dn=%b fault=%b",
               name, $time, got[5:3], got[2], got[1], got[0], exp[5:3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Apply one cycle of inputs, advance the model, queue the expectation.
  task automatic step(input bit a, input bit u, input bit d, input bit o, input bit c);
    bit pulse;
    @(negedge clk);
    activate = a; up_max = u; dn_max = d; obstruct = o; fault_clr = c;
    @(posedge clk);
    #1;
    pulse = a && !prev_act;
    prev_act = a;
    model_step(0, 1'b1, pulse, u, d, o, c);
    model_step(1, 1'b0, pulse, u, d, o, c);
    exp_q.push_back({expect_bits(mode[0]), expect_bits(mode[1])});
  endtask

  // Monitor: compares DUT outputs against queued expectations.
  always @(negedge clk) begin
    logic [11:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      $display("cycle @%0t: rev state=%b exp=%b | stop state=%b exp=%b",
               $time, state_r, e[11:9], state_s, e[5:3]);
      compare("rev_dut", {state_r, up_m_r, dn_m_r, fault_r}, e[11:6]);
      compare("stop_dut", {state_s, up_m_s, dn_m_s, fault_s}, e[5:0]);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ra;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare("reset_rev", {state_r, up_m_r, dn_m_r, fault_r}, 6'b000_000);
    compare("reset_stop", {state_s, up_m_s, dn_m_s, fault_s}, 6'b000_000);
    @(negedge clk);
    rst = 1'b0;

    // open from closed with held button, stop at the upper limit
    step(1, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) step(0, 1, 0, 0, 0);

    // close, obstruct mid-travel: reverse on one DUT, stop on the other
    step(1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);

    // stop / resume reverses direction
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);

    // travel timeout then clear
    step(1, 0, 1, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 1);

    // sensor conflict; clear is gated while both limits are active
    step(1, 1, 0, 0, 0);
    for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    for (int i = 0; i < 2; i++) step(0, 1, 1, 0, 1);
    step(0, 0, 1, 0, 1);

    // asynchronous reset while closing
    step(1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    compare("async_rst_rev", {state_r, up_m_r, dn_m_r, fault_r}, 6'b000_000);
    compare("async_rst_stop", {state_s, up_m_s, dn_m_s, fault_s}, 6'b000_000);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // randomized traffic
    ra = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 4) == 0) ra = ~ra;
      step(ra, ($urandom_range(0, 11) == 0), ($urandom_range(0, 11) == 0),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));
    end

    repeat (2) @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
